// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: Zicsr read-modify-write sequencer between execute and the CSR file.
// Ports: clock/reset (async, active-high); req_* request in (valid/ready);
// csr_addr/csr_rdata/csr_we/csr_wdata to the CSR file; rsp_* response out (valid/ready).
module csr_rmw_unit #(
  parameter int XLEN = 32,
  parameter int RO_CHECK = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_addr,
  input  logic [4:0]      req_rs1,
  input  logic [XLEN-1:0] req_rs1_val,
  output logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  // funct3[2] only selects the source at acceptance; the op is fully described by funct3[1:0]
  logic [1:0] op;
  logic [11:0] addr;
  logic [XLEN-1:0] src, old, new_val;
  logic src_zero, do_write, illegal;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      src <= '0;
      src_zero <= 1'b0;
      old <= '0;
      rsp_rdata <= '0;
      rsp_illegal <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          op <= req_funct3[1:0];
          addr <= req_addr;
          src <= req_funct3[2] ? XLEN'(req_rs1) : req_rs1_val;
          src_zero <= req_rs1 == 5'd0;
          state <= READ;
        end
        READ: begin
          old <= csr_rdata;
          state <= WRITE;
        end
        WRITE: begin
          rsp_rdata <= illegal ? '0 : old;
          rsp_illegal <= illegal;
          state <= RESP;
        end
        default: if (rsp_ready) state <= IDLE;
      endcase
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign csr_addr = (state == READ || state == WRITE) ? addr : '0;
  assign new_val = op == 2'b01 ? src : op == 2'b10 ? (old | src) : op == 2'b11 ? (old & ~src) : '0;
  assign do_write = op == 2'b01 || !src_zero;
  assign illegal = op == 2'b00 || (RO_CHECK != 0 && do_write && addr[11:10] == 2'b11);
  assign csr_we = state == WRITE && do_write && !illegal;
  assign csr_wdata = csr_we ? new_val : '0;
endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb_csr_rmw_unit: scoreboard bench for csr_rmw_unit with a CSR-file stub and reference model.
module tb_csr_rmw_unit;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, csr_we, rsp_valid, rsp_ready, rsp_illegal;
  logic [2:0] req_funct3 = '0;
  logic [11:0] req_addr = '0, csr_addr;
  logic [4:0] req_rs1 = '0;
  logic [31:0] req_rs1_val = '0, csr_rdata, csr_wdata, rsp_rdata;
  logic [31:0] csr_mem [4096];
  logic [31:0] ref_mem [4096];
  logic hold_lo = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, acc = 0;
  typedef struct {logic [31:0] rdata; logic ill;} rsp_t;
  typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
  rsp_t rq[$];
  wr_t wq[$];
  logic [11:0] addrs [6] = '{12'h340, 12'h341, 12'hB00, 12'hF12, 12'hC00, 12'h300};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign csr_rdata = csr_mem[csr_addr];
  always @(negedge clock) if (csr_we) csr_mem[csr_addr] = csr_wdata;

  csr_rmw_unit #(.XLEN(32), .RO_CHECK(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1(req_rs1), .req_rs1_val(req_rs1_val),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs1,
                       input logic [31:0] v, input bit drop);
    int t = 0;
    logic [31:0] src, old, nv;
    bit wr, ill;
    @(posedge clock); #1;
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1 = rs1; req_rs1_val = v;
    @(negedge clock);
    while (!req_ready && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) begin
      chk("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    src = f3[2] ? {27'b0, rs1} : v;
    old = ref_mem[a];
    wr = f3[1:0] == 2'b01 || rs1 != 0;
    ill = f3[1:0] == 2'b00 || (a >= 12'hC00 && wr);
    case (f3[1:0])
      2'b01: nv = src;
      2'b10: nv = old | src;
      default: nv = old & ~src;
    endcase
    @(posedge clock); #1;
    acc = cyc - 1;
    req_valid = 1'b0;
    req_funct3 = 3'($urandom); req_addr = 12'($urandom); req_rs1 = 5'($urandom); req_rs1_val = $urandom;
    if (!drop) begin
      if (wr && !ill) begin
        wq.push_back('{a, nv});
        ref_mem[a] = nv;
      end
      rq.push_back('{ill ? 32'h0 : old, ill});
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((rq.size() != 0 || !req_ready) && t < 200) begin @(negedge clock); t++; end
    if (t >= 200) chk("drain_timeout", rq.size(), 0);
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      rsp_ready = !hold_lo && ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    bit pv = 0, pr = 0, pil = 0;
    logic [31:0] prd = '0;
    rsp_t r;
    wr_t w;
    forever begin
      @(negedge clock);
      if (reset) pv = 0;
      else begin
        if (csr_we) begin
          chk("we_latency", cyc - acc, 2);
          if (wq.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            w = wq.pop_front();
            chk("wr_addr", {20'b0, csr_addr}, {20'b0, w.a});
            chk("wr_data", csr_wdata, w.d);
          end
        end
        if (rsp_valid) begin
          chk("req_ready_in_resp", {31'b0, req_ready}, 0);
          if (!pv) chk("rsp_latency", cyc - acc, 3);
          else if (!pr) begin
            chk("hold_rdata", rsp_rdata, prd);
            chk("hold_illegal", {31'b0, rsp_illegal}, {31'b0, pil});
          end
          if (rsp_ready) begin
            if (rq.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
              r = rq.pop_front();
              chk("rsp_rdata", rsp_rdata, r.rdata);
              chk("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, r.ill});
              chk("write_pending", wq.size(), 0);
            end
          end
        end
        pv = rsp_valid; pr = rsp_ready; prd = rsp_rdata; pil = rsp_illegal;
      end
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      ref_mem[i] = csr_mem[i];
    end
    repeat (2) @(posedge clock); #1;
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_csr_we", {31'b0, csr_we}, 0);
    chk("rst_csr_addr", {20'b0, csr_addr}, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_illegal", {31'b0, rsp_illegal}, 0);
    reset = 1'b0;
    set_csr(12'hF12, 32'h05318008);
    issue(3'b010, 12'hF12, 5'd0, 32'h12345678, 0);
    wait_idle();
    set_csr(12'h340, 32'h11111111);
    issue(3'b001, 12'h340, 5'd7, 32'hDEADBEEF, 0);
    wait_idle();
    set_csr(12'h340, 32'h000000FF);
    issue(3'b111, 12'h340, 5'h0F, 32'hFFFFFFFF, 0);
    issue(3'b110, 12'h340, 5'd0, 32'hFFFFFFFF, 0);
    issue(3'b001, 12'hC00, 5'd0, 32'h0, 0);
    issue(3'b100, 12'h340, 5'd3, 32'h0, 0);
    issue(3'b000, 12'h300, 5'd0, 32'h0, 0);
    issue(3'b001, 12'hB00, 5'd1, 32'hA5A5A5A5, 0);
    wait_idle();
    hold_lo = 1'b1;
    issue(3'b010, 12'h341, 5'd9, 32'h00F0000F, 0);
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clock); t++; end
    chk("hold_rsp_seen", {31'b0, rsp_valid}, 1);
    repeat (5) @(negedge clock);
    hold_lo = 1'b0;
    wait_idle();
    issue(3'b001, 12'h341, 5'd3, 32'hCAFEF00D, 1);
    @(posedge clock); #1;
    chk("drop_we_before", {31'b0, csr_we}, 1);
    reset = 1'b1;
    #1;
    chk("drop_we_after", {31'b0, csr_we}, 0);
    chk("drop_req_ready", {31'b0, req_ready}, 1);
    chk("drop_rsp_valid", {31'b0, rsp_valid}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    issue(3'b010, 12'h341, 5'd0, 32'h0, 0);
    for (int i = 0; i < 150; i++)
      issue(3'($urandom), addrs[$urandom_range(0, 5)],
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, 0);
    wait_idle();
    chk("final_rsp_queue", rq.size(), 0);
    chk("final_wr_queue", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
